pll_clken_gen: RTL and testbench

PLL_CLKEN_GEN -- requirements
Module: pll_clken_gen

---
 rtl/pll_clken_gen_if.sv | 12 +
 rtl/pll_clken_gen.sv | 112 +++++++++++
 tb/tb_pll_clken_gen.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pll_clken_gen_if.sv
// Increment configuration bus for pll_clken_gen: a one-cycle write strobe,
// a target channel and the new phase increment.
interface pll_clken_gen_if #(
  parameter int unsigned ACC_W = 24
) ();
  logic             cfg_wr;
  logic [1:0]       cfg_ch;
  logic [ACC_W-1:0] cfg_inc;

  modport master (output cfg_wr, output cfg_ch, output cfg_inc);
  modport slave  (input  cfg_wr, input  cfg_ch, input  cfg_inc);
endinterface

// File: rtl/pll_clken_gen.sv
// Lock-qualified clock-enable generator: waits for a stable PLL lock, then drives
// per-channel fractional strobes from phase accumulators plus a downstream reset.
module pll_clken_gen #(
  parameter int unsigned           N_CH        = 2,
  parameter int unsigned           ACC_W       = 24,
  parameter int unsigned           LOCK_STABLE = 1024,
  parameter logic [N_CH*ACC_W-1:0] INC_INIT    = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            locked,
  pll_clken_gen_if.slave  cfg,
  output logic [N_CH-1:0] ce,
  output logic            rst_out_n,
  output logic            running,
  output logic [7:0]      lost_cnt
);

  localparam int unsigned CNT_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_STABLE - 1);

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN} state_e;

  state_e           state_q, state_d;
  logic             sync1_q, lock_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       lost_q, lost_d;
  logic             running_q, running_d;
  logic             rst_out_n_q, rst_out_n_d;
  logic [N_CH-1:0]  ce_q, ce_d;
  logic [ACC_W-1:0] acc_q [N_CH];
  logic [ACC_W-1:0] acc_d [N_CH];
  logic [ACC_W-1:0] inc_q [N_CH];
  logic [ACC_W-1:0] inc_d [N_CH];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lost_d      = lost_q;
    running_d   = (state_q == RUN);
    rst_out_n_d = (state_q == RUN);
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        if (!lock_s_q)              state_d = WAIT_LOCK;
        else if (cnt_q == CNT_LAST) state_d = RUN;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      RUN: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Carry out of each add is the strobe; the residue stays in the accumulator.
  always_comb begin
    ce_d = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      inc_d[i] = inc_q[i];
      acc_d[i] = '0;
      if (state_q == RUN) begin
        {ce_d[i], acc_d[i]} = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      end
      if (cfg.cfg_wr && (cfg.cfg_ch == 2'(i))) inc_d[i] = cfg.cfg_inc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      lost_q      <= '0;
      running_q   <= 1'b0;
      rst_out_n_q <= 1'b0;
      ce_q        <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= INC_INIT[i*ACC_W +: ACC_W];
      end
    end else begin
      sync1_q     <= locked;
      lock_s_q    <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lost_q      <= lost_d;
      running_q   <= running_d;
      rst_out_n_q <= rst_out_n_d;
      ce_q        <= ce_d;
      for (int unsigned i = 0; i < N_CH; i++) begin
        acc_q[i] <= acc_d[i];
        inc_q[i] <= inc_d[i];
      end
    end
  end

  assign ce        = ce_q;
  assign running   = running_q;
  assign rst_out_n = rst_out_n_q;
  assign lost_cnt  = lost_q;

endmodule

// File: tb/tb_pll_clken_gen.sv
// Bench for pll_clken_gen (N_CH=2, ACC_W=8, LOCK_STABLE=16, inc reset {0x80,0x40}):
// per-cycle scoreboard from a phase-sum model plus directed latency/rate checks.
module tb_pll_clken_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       locked;
  logic [1:0] ce;
  logic       rst_out_n;
  logic       running;
  logic [7:0] lost_cnt;

  int n_chk = 0;
  int n_err = 0;

  pll_clken_gen_if #(.ACC_W(8)) bus ();

  pll_clken_gen #(
    .N_CH       (2),
    .ACC_W      (8),
    .LOCK_STABLE(16),
    .INC_INIT   (16'h8040)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .locked   (locked),
    .cfg      (bus),
    .ce       (ce),
    .rst_out_n(rst_out_n),
    .running  (running),
    .lost_cnt (lost_cnt)
  );

  always #5 clk = ~clk;

  function automatic void check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endfunction

  // Reference model: strobes derived from an unbounded phase sum rather than a wrapping register.
  logic [10:0] sb[$];
  logic        m_sync1, m_lock_s;
  int          m_st, m_old_st, m_cnt, m_lost;
  logic        m_run;
  logic [1:0]  m_ce;
  longint      m_phase[2];
  longint      m_hi;
  logic [7:0]  m_inc[2];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_sync1 = 1'b0; m_lock_s = 1'b0; m_st = 0; m_cnt = 0; m_lost = 0;
      m_run = 1'b0; m_ce = 2'b00; m_phase[0] = 0; m_phase[1] = 0;
      m_inc[0] = 8'h40; m_inc[1] = 8'h80;
      sb.delete();
    end else begin
      m_old_st = m_st;
      for (int ch = 0; ch < 2; ch++) begin
        if (m_old_st == 2) begin
          m_hi = m_phase[ch] >> 8;
          m_phase[ch] = m_phase[ch] + longint'(m_inc[ch]);
          m_ce[ch] = ((m_phase[ch] >> 8) != m_hi);
        end else begin
          m_phase[ch] = 0;
          m_ce[ch] = 1'b0;
        end
      end
      m_run = (m_old_st == 2);
      case (m_old_st)
        0: if (m_lock_s) begin m_st = 1; m_cnt = 0; end
        1: begin
          if (!m_lock_s) m_st = 0;
          else if (m_cnt == 15) m_st = 2;
          else m_cnt++;
        end
        default: if (!m_lock_s) begin m_st = 0; if (m_lost < 255) m_lost++; end
      endcase
      m_lock_s = m_sync1;
      m_sync1  = locked;
      if (bus.cfg_wr && bus.cfg_ch < 2) m_inc[bus.cfg_ch[0]] = bus.cfg_inc;
      sb.push_back({m_ce, m_run, 8'(m_lost)});
    end
  end

  always @(negedge clk) begin
    logic [10:0] e;
    if (reset_n && sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_ce", 32'(ce), 32'(e[10:9]));
      check("sb_running", 32'(running), 32'(e[8]));
      check("sb_rst_out_n", 32'(rst_out_n), 32'(e[8]));
      check("sb_lost_cnt", 32'(lost_cnt), 32'(e[7:0]));
    end
  end

  task automatic wait_run(input int budget, output int n);
    n = 0;
    while (!running && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic next_ce(input int ch, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ce[ch] && n < 64);
  endtask

  task automatic count_ce(input int ch, input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (ce[ch]) n++;
    end
  endtask

  task automatic write_inc(input logic [1:0] ch, input logic [7:0] val);
    bus.cfg_wr = 1'b1; bus.cfg_ch = ch; bus.cfg_inc = val;
    @(negedge clk);
    bus.cfg_wr = 1'b0;
  endtask

  initial begin
    int n, k, ce_seen;
    reset_n = 1'b0; locked = 1'b1;
    bus.cfg_wr = 1'b0; bus.cfg_ch = 2'd0; bus.cfg_inc = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ce", 32'(ce), 0);
    check("rst_running", 32'(running), 0);
    check("rst_rst_out_n", 32'(rst_out_n), 0);
    check("rst_lost_cnt", 32'(lost_cnt), 0);

    // 2 sync edges + 1 WAIT_LOCK decision + 16 STABLE + 1 output register = 20
    #1 reset_n = 1'b1;
    wait_run(64, n);
    check("lock_latency", n, 20);
    check("rst_out_n_at_run", 32'(rst_out_n), 1);

    next_ce(0, k); check("first_ce0_after_run", k, 3);
    next_ce(0, k); check("ce0_period_a", k, 4);
    next_ce(0, k); check("ce0_period_b", k, 4);
    next_ce(1, k); check("ce1_align", k, 2);
    next_ce(1, k); check("ce1_period", k, 2);

    write_inc(2'd3, 8'h11);
    count_ce(0, 16, k); check("bad_ch_ce0_count", k, 4);
    count_ce(1, 16, k); check("bad_ch_ce1_count", k, 8);

    write_inc(2'd1, 8'h00);
    count_ce(1, 20, k); check("inc0_ce1_silent", k, 0);

    write_inc(2'd0, 8'h03);
    count_ce(0, 256, k); check("inc3_256_cycles", k, 3);

    // Mid-run reset; lock blip at stability count 10 forces full requalification
    @(negedge clk); #1 reset_n = 1'b0;
    #1;
    check("midrst_ce", 32'(ce), 0);
    check("midrst_running", 32'(running), 0);
    check("midrst_rst_out_n", 32'(rst_out_n), 0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    n = 0; ce_seen = 0;
    while (!running && n < 80) begin
      @(negedge clk);
      n++;
      if (ce != 2'b00) ce_seen++;
      if (n == 11) locked = 1'b0;
      if (n == 12) locked = 1'b1;
    end
    check("requal_latency", n, 32);
    check("requal_no_strobe", ce_seen, 0);
    check("requal_lost_cnt", 32'(lost_cnt), 0);

    for (int d = 0; d < 300; d++) begin
      @(negedge clk); locked = 1'b0;
      @(negedge clk); locked = 1'b1;
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        if (d == 5 && j == 0) begin
          bus.cfg_wr = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_inc = 8'h20;
        end else begin
          bus.cfg_wr = 1'b0;
        end
      end
      check("drop_rst_out_n", 32'(rst_out_n), 0);
      check("drop_ce", 32'(ce), 0);
      wait_run(40, n);
      check("drop_relock", 32'(running), 1);
    end
    check("lost_cnt_saturated", 32'(lost_cnt), 255);

    next_ce(0, k);
    next_ce(0, k); check("write_on_loss_ce0_period", k, 8);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
